// File: rtl/tff_bank_ctrl_if.sv
// Command port between a host/sequencer and tff_bank_ctrl.
// The master offers a command; the slave (controller) signals when it can take one.
interface tff_bank_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [CNT_W-1:0] cmd_steps;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_data,
    output cmd_steps,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_data,
    input  cmd_steps,
    output cmd_ready
  );
endinterface

// File: rtl/tff_bank_ctrl.sv
// Sequences an external bank of toggle flip-flops: clear, parallel load by toggling
// mismatched bits, and bounded up/down counting with a sticky wrap flag.
module tff_bank_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  tff_bank_ctrl_if.slave        cmd,
  input  logic [WIDTH-1:0]      q_in,
  output logic [WIDTH-1:0]      t_out,
  output logic                  busy,
  output logic                  done,
  output logic                  wrapped
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_APPLY = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_UP    = 2'b10;
  localparam logic [1:0] OP_DOWN  = 2'b11;

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic             wrapped_q, wrapped_d;

  // Count toggle vectors: bit i flips when every lower bit is 1 (up) or 0 (down).
  logic [WIDTH-1:0] up_t;
  logic [WIDTH-1:0] dn_t;

  assign up_t[0] = 1'b1;
  assign dn_t[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 1; gi < WIDTH; gi++) begin : g_carry
      assign up_t[gi] = up_t[gi-1] &  q_in[gi-1];
      assign dn_t[gi] = dn_t[gi-1] & ~q_in[gi-1];
    end
  endgenerate

  logic             is_down;
  logic [WIDTH-1:0] count_t;
  logic             wrap_hit;
  logic             accept;

  assign is_down  = (op_q == OP_DOWN);
  assign count_t  = is_down ? dn_t : up_t;
  assign wrap_hit = is_down ? ~|q_in : &q_in;
  assign accept   = (state_q == S_IDLE) && cmd.cmd_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= OP_CLEAR;
      target_q    <= '0;
      remaining_q <= '0;
      wrapped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      target_q    <= target_d;
      remaining_q <= remaining_d;
      wrapped_q   <= wrapped_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    target_d    = target_q;
    remaining_d = remaining_q;
    wrapped_d   = wrapped_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d        = cmd.cmd_op;
          target_d    = (cmd.cmd_op == OP_LOAD) ? cmd.cmd_data : '0;
          remaining_d = cmd.cmd_steps;
          wrapped_d   = 1'b0;
          if ((cmd.cmd_op == OP_CLEAR) || (cmd.cmd_op == OP_LOAD)) begin
            state_d = S_APPLY;
          end else if (cmd.cmd_steps != '0) begin
            state_d = S_RUN;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_APPLY: begin
        state_d = S_DONE;
      end
      S_RUN: begin
        remaining_d = remaining_q - CNT_W'(1);
        if (wrap_hit) begin
          wrapped_d = 1'b1;
        end
        if (remaining_q == CNT_W'(1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outside APPLY/RUN the T inputs stay low so the bank holds its value.
  always_comb begin
    t_out         = '0;
    busy          = 1'b0;
    done          = 1'b0;
    cmd.cmd_ready = 1'b0;

    case (state_q)
      S_IDLE: begin
        cmd.cmd_ready = 1'b1;
      end
      S_APPLY: begin
        t_out = q_in ^ target_q;
        busy  = 1'b1;
      end
      S_RUN: begin
        t_out = count_t;
        busy  = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        t_out = '0;
      end
    endcase
  end

  assign wrapped = wrapped_q;

endmodule
